// File: rtl/timebase_pkg.sv
// timebase_pkg: op codes, state encoding and default sizing shared by
// the board time-base controller and its divider counter.
package timebase_pkg;

    localparam int          CNT_W_DEF       = 25;
    localparam int unsigned DEFAULT_DIV_DEF = 24999999;
    localparam int          TCNT_W_DEF      = 8;

    typedef enum logic [1:0] {
        OP_STOP    = 2'b00,
        OP_RUN     = 2'b01,
        OP_ONESHOT = 2'b10,
        OP_LOAD    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SHOT = 2'b10
    } state_e;

endpackage

// File: rtl/timebase_counter.sv
// timebase_counter: loadable down-counter that parks at zero and
// flags expiry while enabled.
module timebase_counter
    import timebase_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/timebase_ctrl.sv
// timebase_ctrl: command-driven sequencer for the board time base,
// producing a tick strobe, a square wave and one-shot completion.
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int          TCNT_W      = TCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_div,
    output logic              tick,
    output logic              sq_out,
    output logic              done,
    output logic              busy,
    output logic [TCNT_W-1:0] tick_cnt
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;
    logic                sq_q, sq_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic acc;
    logic stop_acc, run_acc, shot_acc, load_acc;
    logic busy_w, start, expire;
    logic cnt_en, cnt_load;
    logic [CNT_W-1:0] cnt_val;

    assign acc      = cmd_valid && !pend_v_q;
    assign stop_acc = acc && (cmd_op == OP_STOP);
    assign run_acc  = acc && (cmd_op == OP_RUN);
    assign shot_acc = acc && (cmd_op == OP_ONESHOT);
    assign load_acc = acc && (cmd_op == OP_LOAD);

    assign busy_w = (state_q != ST_IDLE);
    assign start  = !busy_w && (run_acc || shot_acc);

    // STOP freezes the counter, which also suppresses a same-edge expiry
    assign cnt_en   = busy_w && !stop_acc;
    assign cnt_load = start || expire;

    always_comb begin
        cnt_val = div_q;
        if (!start) begin
            if (load_acc) begin
                cnt_val = cmd_div;
            end else if (pend_v_q) begin
                cnt_val = pend_q;
            end
        end
    end

    timebase_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run_acc) begin
                    state_d = ST_RUN;
                end else if (shot_acc) begin
                    state_d = ST_SHOT;
                end
            end
            ST_RUN: begin
                if (stop_acc) begin
                    state_d = ST_IDLE;
                end else if (shot_acc) begin
                    state_d = ST_SHOT;
                end
            end
            ST_SHOT: begin
                if (stop_acc) begin
                    state_d = ST_IDLE;
                end else if (run_acc) begin
                    state_d = ST_RUN;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_d   = expire;
        done_d   = expire && (state_q == ST_SHOT) && !run_acc;
        sq_d     = sq_q;
        tcnt_d   = tcnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        if (stop_acc) begin
            sq_d = 1'b0;
        end else if (expire) begin
            sq_d = !sq_q;
        end

        if (start) begin
            tcnt_d = '0;
        end else if (expire) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end

        // a LOAD landing on the expiry edge feeds that same reload directly
        if (load_acc) begin
            if (!busy_w || expire) begin
                div_d = cmd_div;
            end else begin
                pend_d   = cmd_div;
                pend_v_d = 1'b1;
            end
        end else if (expire && pend_v_q) begin
            div_d    = pend_q;
            pend_v_d = 1'b0;
        end

        if (stop_acc) begin
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= CNT_W'(DEFAULT_DIV);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            sq_q     <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            sq_q     <= sq_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign cmd_ready = !pend_v_q;
    assign busy      = busy_w;
    assign tick      = tick_q;
    assign done      = done_q;
    assign sq_out    = sq_q;
    assign tick_cnt  = tcnt_q;

endmodule

// File: doc/timebase_ctrl.md
# timebase_ctrl

Command-driven controller for the board time base: it sequences a programmable down-counter divider and emits a one-cycle `tick` strobe plus a toggling square wave (`sq_out`). The divider can run continuously, fire once, or stop, and its divisor can be reloaded. It sits between front-panel/FSM logic issuing commands and the display, stopwatch and debounce blocks that consume `tick` as a clock enable. At the default setting on the 50 MHz board clock, `sq_out` is 1 Hz.

## Interface
- `CNT_W`, 25, width of the divisor and the counter.
- `DEFAULT_DIV`, 24999999, divisor loaded at reset; tick period is DIV+1 clk cycles.
- `TCNT_W`, 8, width of `tick_cnt`.
---
- `clk`  in  1  board clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  00 STOP, 01 RUN, 10 ONESHOT, 11 LOAD.
- `cmd_div`  in  CNT_W  divisor for LOAD; ignored otherwise.
- `tick`  out  1  one-cycle strobe at each expiry.
- `sq_out`  out  1  toggles on every tick.
- `done`  out  1  one-cycle pulse on the ONESHOT expiry (coincident with `tick`).
- `busy`  out  1  high in RUN or SHOT.
- `tick_cnt`  out  TCNT_W  ticks since last start; wraps modulo 2^TCNT_W.

## Operation
- **States:** IDLE, RUN, SHOT.
- **Registers:** `div_reg`, counter `cnt`, pending divisor `pend_div` with flag `pend_v`.
- **Reset values:** state=IDLE, `cnt`=0, `div_reg`=DEFAULT_DIV, `pend_v`=0, `tick`=0, `done`=0, `sq_out`=0, `tick_cnt`=0. Derived outputs: `busy`=0, `cmd_ready`=1.
- **`cmd_ready`:** `cmd_ready = !pend_v`.
- **IDLE + RUN:** go to RUN, `cnt`<=`div_reg`, `tick_cnt`<=0.
- **IDLE + ONESHOT:** same as IDLE + RUN, but go to SHOT.
- **IDLE + LOAD:** `div_reg`<=`cmd_div` immediately.
- **RUN/SHOT + LOAD:** `pend_div`<=`cmd_div`, `pend_v`<=1. The pending value is applied at the next expiry reload.
- **RUN/SHOT, each edge:**
  - If `cnt`!=0, decrement `cnt`.
  - If `cnt`==0 (expiry): `tick`<=1, `sq_out`<=~`sq_out`, `tick_cnt`++.
  - On expiry, `cnt`<=(`pend_v` ? `pend_div` : `div_reg`). If `pend_v`, also `div_reg`<=`pend_div` and `pend_v`<=0.
  - In SHOT, expiry also sets `done`<=1 and returns to IDLE.
- **RUN + ONESHOT:** go to SHOT with no reload; finishes at the next expiry.
- **SHOT + RUN:** go to RUN with no reload.
- **RUN + RUN, SHOT + ONESHOT:** no effect.
- **STOP in any state:** go to IDLE. `sq_out`<=0, `pend_v`<=0 with the pending divisor discarded. `cnt` and `tick_cnt` hold.
- **Divisor 0:** valid; in RUN, `tick` is high every cycle and `sq_out` toggles every cycle.

## Timing
- `tick`, `done` and `sq_out` are registered; there is no combinational path from `cmd_*` to any output except `cmd_ready`.
- **First tick:** with RUN accepted at edge 0, `tick` is high in the cycle after edge DIV+1. Subsequent ticks come every DIV+1 cycles.
- **Simultaneous events on the expiry edge:**
  - STOP wins: no tick, no `tick_cnt` increment.
  - LOAD takes effect for that same reload.
  - ONESHOT in RUN: this expiry ticks and the block enters SHOT; SHOT ends at the following expiry.
- **Reset mid-operation:** asserting `rst` forces all reset values immediately, with no clock required. A tick in flight is dropped.
- **Width rules:** `cnt` is unsigned CNT_W bits. `tick_cnt` wraps from 2^TCNT_W−1 to 0 without flagging.

## Structure
- Package `timebase_pkg` holds:
  - op codes `OP_STOP`, `OP_RUN`, `OP_ONESHOT`, `OP_LOAD`;
  - state encoding `ST_IDLE`, `ST_RUN`, `ST_SHOT`;
  - default `CNT_W`/`DEFAULT_DIV` constants.
- Sub-module `timebase_counter`: CNT_W down-counter with `load`, `load_val`, `en` inputs and an `expire` output (`cnt==0 && en`). It holds no FSM.
- `timebase_ctrl` contains the FSM, divisor/pending registers and output registers.

## Test plan
- **Reset:** reset, then RUN with default divisor overridden by LOAD 3 -> `tick` pulses every 4 cycles, first pulse 4 cycles after accept; `sq_out` 0,1,0,1 per tick; `tick_cnt` 1,2,3.
- **ONESHOT:** ONESHOT with div 5 -> single `tick`+`done` 6 cycles after accept; `busy` falls the same edge; no further ticks over 50 cycles.
- **LOAD while running:** LOAD 1 while RUN at div 7 -> `cmd_ready` low until the next expiry; the expiry after that uses period 2; a second LOAD is stalled while `pend_v`=1.
- **STOP on expiry edge:** STOP on the exact expiry edge (div 2) -> no `tick`, `tick_cnt` unchanged, `sq_out`=0, `busy`=0.
- **Divisor 0 and wrap:** div 0 RUN for 300 cycles -> `tick` high continuously, `tick_cnt` wraps 255->0 once (ends at 44).
- **Asynchronous reset:** async `rst` pulse mid-cycle during RUN -> outputs return to reset values before the next clock edge; `div_reg`=24999999.
